// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and helpers
// Used by uart_tx, uart_tx_if and uart_baud_gen (and the debug-port receiver).
package uart_pkg;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_OVERSAMPLE     = 16;
  localparam int UART_BAUD_ACC_WIDTH = 11;
  localparam int UART_BAUD_ACC_INCR  = 151;  // 25 MHz * 151 / 2^11 = 16 x 115200

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte valid/ready handshake into the UART transmitter
// i_byte  : byte to send, sampled on handshake (master -> slave)
// i_valid : i_byte valid (master -> slave)
// o_ready : holding register empty (slave -> master)
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] i_byte;
  logic                      i_valid;
  logic                      o_ready;

  modport master (output i_byte, output i_valid, input o_ready);
  modport slave  (input i_byte, input i_valid, output o_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional baud accumulator producing a 16x oversample tick
// i_clk    : system clock
// i_rst_n  : asynchronous active-low reset
// o_tick16 : one-cycle pulse at 16x the baud rate
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int baud_acc_width = UART_BAUD_ACC_WIDTH,
  parameter int baud_acc_incr  = UART_BAUD_ACC_INCR
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick16
);

  logic [baud_acc_width-1:0] acc_q;
  logic [baud_acc_width-1:0] acc_d;
  logic                      carry;
  logic                      tick_q;

  // Free-running: the carry-out of the modulo add is the tick; the
  // remainder carries the fractional phase into the next period.
  always_comb begin
    {carry, acc_d} = {1'b0, acc_q} + (baud_acc_width + 1)'(baud_acc_incr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= carry;
    end
  end

  assign o_tick16 = tick_q;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a one-byte holding register
// Optional even-parity bit when UART_TX_PARITY_EN is defined (frame becomes 11 bits).
// i_clk   : system clock
// i_rst_n : asynchronous active-low reset
// bus     : uart_tx_if.slave byte handshake (i_byte, i_valid, o_ready)
// o_tx    : serial line, idle high, registered
// o_busy  : frame in flight or holding register full, registered
module uart_tx
  import uart_pkg::*;
#(
  parameter int baud_acc_width = UART_BAUD_ACC_WIDTH,
  parameter int baud_acc_incr  = UART_BAUD_ACC_INCR
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  uart_tx_if.slave   bus,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int SUB_W = $clog2(UART_OVERSAMPLE);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(UART_OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  tx_state_e                 state_q, state_d;
  logic [SUB_W-1:0]          sub_q, sub_d;
  logic [IDX_W-1:0]          bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] hold_q, hold_d;
  logic                      hold_full_q, hold_full_d;
  logic                      ready_q;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      tick16;
  logic                      accept;
  logic                      bit_end;
  logic                      load;

  uart_baud_gen #(
    .baud_acc_width (baud_acc_width),
    .baud_acc_incr  (baud_acc_incr)
  ) u_baud_gen (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .o_tick16 (tick16)
  );

  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;

    // ready_q mirrors !hold_full_q, so accept and load are mutually exclusive.
    accept  = bus.i_valid && ready_q;
    bit_end = tick16 && (sub_q == SUB_LAST);

    if (accept) begin
      hold_d      = bus.i_byte;
      hold_full_d = 1'b1;
    end

    if (state_q != TX_IDLE && tick16) begin
      sub_d = sub_q + 1'b1;
    end

    case (state_q)
      TX_IDLE: begin
        if (tick16 && hold_full_q) load = 1'b1;
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end) state_d = TX_STOP;
      end
`endif
      TX_STOP: begin
        // A waiting byte starts its start bit on the same edge: no idle bit.
        if (bit_end) begin
          if (hold_full_q) load = 1'b1;
          else             state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      state_d     = TX_START;
      sub_d       = '0;
      bit_d       = '0;
    end

    // Line level follows the next state so o_tx changes on the same edge.
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_d = even_parity(shift_d);
`endif
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_d != TX_IDLE) || hold_full_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= TX_IDLE;
      sub_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= !hold_full_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_ready = ready_q;
  assign o_tx        = tx_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

  localparam int BIT_CLKS  = 217;
  localparam int HALF_CLKS = 108;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_CLKS = 2387;
`else
  localparam int FRAME_CLKS = 2170;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic tx;
  logic busy;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic rdy_prev = 1'b1;
  int   rdy_rises = 0;

  uart_tx_if tx_if ();

  uart_tx dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (tx_if),
    .o_tx    (tx),
    .o_busy  (busy)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_if.o_ready === 1'b1 && rdy_prev === 1'b0) rdy_rises++;
    rdy_prev = tx_if.o_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Present a byte and return the cycle number of the accepting edge.
  task automatic send(input logic [7:0] b, output int acc_cyc);
    int n;
    n = 0;
    tx_if.i_byte  = b;
    tx_if.i_valid = 1'b1;
    while (tx_if.o_ready !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    tx_if.i_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_fall(output int fall_cyc, output logic got);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    got      = (tx === 1'b0);
    fall_cyc = cyc;
  endtask

  // Sample every bit at its centre, measured from the start-bit falling edge.
  task automatic capture(output logic [7:0] d, output logic sb, output logic pb,
                         output logic stb, output int fall_cyc, output logic got);
    d = '0;
    pb = 1'b0;
    wait_fall(fall_cyc, got);
    repeat (HALF_CLKS) @(negedge clk);
    sb = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CLKS) @(negedge clk);
      d[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (BIT_CLKS) @(negedge clk);
    pb = tx;
`endif
    repeat (BIT_CLKS) @(negedge clk);
    stb = tx;
  endtask

  task automatic wait_idle(output int idle_cyc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    idle_cyc = cyc;
  endtask

  initial begin
    logic [7:0] d;
    logic       sb, pb, stb, got;
    int         acc, fall, idle, bad, r0;
    logic [7:0] sd [3];
    logic       ssb [3];
    logic       sst [3];
    logic       sgot [3];
    int         sfall [3];
    logic [7:0] sbytes [3];
    logic       drv_ok;

    rst_n         = 1'b0;
    tx_if.i_byte  = 8'h00;
    tx_if.i_valid = 1'b0;
    @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_ready", tx_if.o_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_if.o_ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_10000_bad_cycles", bad, 0);

    send(8'hA5, acc);
    check("a5_ready_low_after_accept", tx_if.o_ready, 1'b0);
    capture(d, sb, pb, stb, fall, got);
    check("a5_start_seen", got, 1'b1);
    check_range("a5_accept_to_start", fall - acc, 1, 16);
    check("a5_start_bit", sb, 1'b0);
    check("a5_data", d, 8'hA5);
`ifdef UART_TX_PARITY_EN
    check("a5_parity", pb, 1'b0);
`endif
    check("a5_stop_bit", stb, 1'b1);
    wait_idle(idle);
    check_range("a5_frame_clocks", idle - fall, FRAME_CLKS - 2, FRAME_CLKS + 2);
    check("a5_ready_after", tx_if.o_ready, 1'b1);

    sbytes[0] = 8'h00;
    sbytes[1] = 8'hFF;
    sbytes[2] = 8'h55;
    drv_ok = 1'b1;
    r0 = rdy_rises;
    fork
      begin
        int n;
        for (int k = 0; k < 3; k++) begin
          tx_if.i_byte  = sbytes[k];
          tx_if.i_valid = 1'b1;
          n = 0;
          while (tx_if.o_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
          end
          if (tx_if.o_ready !== 1'b1) drv_ok = 1'b0;
          @(posedge clk);
          #1;
        end
        tx_if.i_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          capture(sd[k], ssb[k], pb, sst[k], sfall[k], sgot[k]);
        end
      end
    join
    check("stream_driver_ok", drv_ok, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stream%0d_seen", k), sgot[k], 1'b1);
      check($sformatf("stream%0d_start", k), ssb[k], 1'b0);
      check($sformatf("stream%0d_data", k), sd[k], sbytes[k]);
      check($sformatf("stream%0d_stop", k), sst[k], 1'b1);
    end
    check_range("stream_gap_0_1", sfall[1] - sfall[0], FRAME_CLKS - 2, FRAME_CLKS + 2);
    check_range("stream_gap_1_2", sfall[2] - sfall[1], FRAME_CLKS - 2, FRAME_CLKS + 2);
    wait_idle(idle);
    check("stream_ready_rises", rdy_rises - r0, 3);
    check_range("stream_last_frame_clocks", idle - sfall[2], FRAME_CLKS - 2, FRAME_CLKS + 2);

    send(8'h3C, acc);
    wait_fall(fall, got);
    check("rst_3c_start_seen", got, 1'b1);
    repeat (HALF_CLKS + 3 * BIT_CLKS) @(negedge clk);
    check("rst_busy_mid_frame", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_tx_immediate", tx, 1'b1);
    check("rst_busy_immediate", busy, 1'b0);
    check("rst_ready_immediate", tx_if.o_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("rst_quiet_after_release", bad, 0);
    send(8'h81, acc);
    capture(d, sb, pb, stb, fall, got);
    check("rst_81_seen", got, 1'b1);
    check("rst_81_start", sb, 1'b0);
    check("rst_81_data", d, 8'h81);
    check("rst_81_stop", stb, 1'b1);
    wait_idle(idle);
    check_range("rst_81_frame_clocks", idle - fall, FRAME_CLKS - 2, FRAME_CLKS + 2);

`ifdef UART_TX_PARITY_EN
    send(8'h07, acc);
    capture(d, sb, pb, stb, fall, got);
    check("par_07_data", d, 8'h07);
    check("par_07_parity", pb, 1'b1);
    check("par_07_stop", stb, 1'b1);
    wait_idle(idle);
    send(8'h03, acc);
    capture(d, sb, pb, stb, fall, got);
    check("par_03_data", d, 8'h03);
    check("par_03_parity", pb, 1'b0);
    check("par_03_stop", stb, 1'b1);
    wait_idle(idle);
    check_range("par_03_frame_clocks", idle - fall, FRAME_CLKS - 2, FRAME_CLKS + 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
